// File: rtl/imem_dmem_arbiter.sv
// Shares one RAM port between fetch reads and data reads/writes; data has priority until fetch has
// waited STARVE_MAX data grants. Define ARB_STATS_EN to add grant/stall counters.
module imem_dmem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              iflush,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       igrant_cnt,
  output logic [31:0]       dgrant_cnt,
  output logic [31:0]       istall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t            r_state;
  logic [3:0]        r_starve;
  logic              r_flushed;
  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic [WORD_W-1:0] r_iload;
  logic [WORD_W-1:0] r_dload;

  logic w_ireq;
  logic w_dreq;
  logic w_force;
  logic w_grant_d;
  logic w_grant_i;

  assign w_ireq    = iREN & ~iflush;
  assign w_dreq    = dREN | dWEN;
  assign w_force   = w_ireq & (r_starve == SMAX);
  assign w_grant_d = (r_state == IDLE) & w_dreq & ~w_force;
  assign w_grant_i = (r_state == IDLE) & ~w_grant_d & w_ireq;

  // A squash arriving in the completing cycle also kills the hit.
  assign ihit = (r_state == IFETCH) & ram_ready & ~r_flushed & ~iflush;
  assign dhit = (r_state == DACCESS) & ram_ready;

  assign iload     = ihit ? ram_load : r_iload;
  assign dload     = dhit ? ram_load : r_dload;
  assign ram_REN   = r_ren;
  assign ram_WEN   = r_wen;
  assign ram_addr  = r_addr;
  assign ram_store = r_store;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_flushed <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= DACCESS;
            r_addr  <= daddr;
            r_store <= dstore;
            r_ren   <= ~dWEN;
            r_wen   <= dWEN;
          end else if (w_grant_i) begin
            r_state <= IFETCH;
            r_addr  <= iaddr;
            r_ren   <= 1'b1;
          end
        end
        IFETCH: begin
          // The RAM cannot abort, so a squashed fetch still runs to ram_ready.
          if (ram_ready) begin
            r_state   <= IDLE;
            r_ren     <= 1'b0;
            r_flushed <= 1'b0;
          end else if (iflush) begin
            r_flushed <= 1'b1;
          end
        end
        DACCESS: begin
          if (ram_ready) begin
            r_state <= IDLE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_starve <= '0;
    end else if (!iREN) begin
      r_starve <= '0;
    end else if (w_grant_d && w_ireq) begin
      if (r_starve != SMAX) r_starve <= r_starve + 4'd1;
    end else if (w_grant_i) begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iload <= '0;
      r_dload <= '0;
    end else begin
      if (ihit) r_iload <= ram_load;
      if (dhit) r_dload <= ram_load;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      igrant_cnt <= '0;
      dgrant_cnt <= '0;
      istall_cnt <= '0;
    end else begin
      if (w_grant_i)     igrant_cnt <= igrant_cnt + 32'd1;
      if (w_grant_d)     dgrant_cnt <= dgrant_cnt + 32'd1;
      if (iREN && !ihit) istall_cnt <= istall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios with literal expectations, then random traffic
// against a pending-access reference model checked every cycle.
module tb_imem_dmem_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, iflush = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        ihit, dhit, ram_REN, ram_WEN;
  logic [31:0] iload, dload, ram_addr, ram_store;
  logic [31:0] ram_load = '0;
  logic        ram_ready = 1'b0;
`ifdef ARB_STATS_EN
  logic [31:0] igrant_cnt, dgrant_cnt, istall_cnt;
`endif

  imem_dmem_arbiter #(.WORD_W(32), .ADDR_W(32), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iflush(iflush), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready)
`ifdef ARB_STATS_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .istall_cnt(istall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM responder: ram_lat>0 gives a fixed latency and ram_word, 0 gives random latency/data.
  int          ram_lat = 1;
  logic [31:0] ram_word = '0;
  bit          ram_noise = 1'b0;
  int          age = 0, target = 1;

  always @(posedge CLK) begin
    #1;
    if (RST || !(ram_REN || ram_WEN)) begin
      age       = 0;
      ram_ready = ram_noise && !RST && ($urandom % 4 == 0);
      ram_load  = $urandom;
    end else begin
      age++;
      if (age == 1) target = (ram_lat > 0) ? ram_lat : $urandom_range(1, 3);
      ram_ready = (age == target);
      ram_load  = (ram_lat > 0) ? ram_word : $urandom;
    end
  end

  // Reference model: at most one pending access (kind 0 none, 1 fetch, 2 data).
  int          m_kind = 0, m_starve = 0;
  logic [31:0] m_addr = '0, m_store = '0, m_iload = '0, m_dload = '0;
  bit          m_wr = 1'b0, m_fl = 1'b0;
  bit          e_ihit, e_dhit, e_ren, e_wen, ireq, gd, gi;
`ifdef ARB_STATS_EN
  logic [31:0] m_ig = '0, m_dg = '0, m_is = '0;
`endif

  always @(negedge CLK) begin
    if (RST) begin
      m_kind = 0; m_starve = 0; m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
      m_wr = 1'b0; m_fl = 1'b0;
      chk("rst_ihit", ihit, 0);       chk("rst_dhit", dhit, 0);
      chk("rst_ram_REN", ram_REN, 0); chk("rst_ram_WEN", ram_WEN, 0);
      chk("rst_iload", iload, 0);     chk("rst_dload", dload, 0);
      chk("rst_ram_addr", ram_addr, 0); chk("rst_ram_store", ram_store, 0);
`ifdef ARB_STATS_EN
      m_ig = '0; m_dg = '0; m_is = '0;
      chk("rst_igrant", igrant_cnt, 0); chk("rst_dgrant", dgrant_cnt, 0); chk("rst_istall", istall_cnt, 0);
`endif
    end else begin
      e_ren  = (m_kind == 1) || (m_kind == 2 && !m_wr);
      e_wen  = (m_kind == 2) && m_wr;
      e_ihit = (m_kind == 1) && ram_ready && !m_fl && !iflush;
      e_dhit = (m_kind == 2) && ram_ready;
      chk("ihit", ihit, e_ihit);
      chk("dhit", dhit, e_dhit);
      chk("ram_REN", ram_REN, e_ren);
      chk("ram_WEN", ram_WEN, e_wen);
      chk("iload", iload, e_ihit ? ram_load : m_iload);
      chk("dload", dload, e_dhit ? ram_load : m_dload);
      if (m_kind != 0) chk("ram_addr", ram_addr, m_addr);
      if (e_wen) chk("ram_store", ram_store, m_store);
`ifdef ARB_STATS_EN
      chk("igrant_cnt", igrant_cnt, m_ig);
      chk("dgrant_cnt", dgrant_cnt, m_dg);
      chk("istall_cnt", istall_cnt, m_is);
      if (iREN && !e_ihit) m_is = m_is + 1;
`endif
      if (e_ihit) m_iload = ram_load;
      if (e_dhit) m_dload = ram_load;
      ireq = iREN && !iflush;
      gd = 1'b0; gi = 1'b0;
      if (m_kind == 0) begin
        if ((dREN || dWEN) && !(ireq && m_starve == SM)) gd = 1'b1;
        else if (ireq) gi = 1'b1;
      end else if (ram_ready) begin
        m_kind = 0; m_fl = 1'b0;
      end else if (m_kind == 1 && iflush) begin
        m_fl = 1'b1;
      end
      if (gd) begin m_kind = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN; end
      if (gi) begin m_kind = 1; m_addr = iaddr; end
      if (!iREN) m_starve = 0;
      else if (gd && ireq) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else if (gi) m_starve = 0;
`ifdef ARB_STATS_EN
      if (gi) m_ig = m_ig + 1;
      if (gd) m_dg = m_dg + 1;
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int          cnt, hitc, dhc, ndh;
  logic [31:0] v, a;
  bit          ih, dh;

  initial begin
    idle(2);
    RST = 1'b0;

    // Fetch only, RAM latency 2.
    ram_lat = 2; ram_word = 32'hDEADBEEF;
    iREN = 1'b1; iaddr = 32'h100;
    cnt = 0; hitc = -1; v = '0; a = '0;
    for (int c = 0; c < 10 && hitc < 0; c++) begin
      @(negedge CLK);
      if (ram_REN) begin cnt++; a = ram_addr; end
      if (ihit) begin hitc = c; v = iload; end
      @(posedge CLK); #1;
      if (hitc >= 0) iREN = 1'b0;
    end
    chk("t1_ren_cycles", cnt, 2);
    chk("t1_ram_addr", a, 32'h100);
    chk("t1_hit_cycle", hitc, 2);
    chk("t1_iload", v, 32'hDEADBEEF);
    @(negedge CLK);
    chk("t1_iload_hold", iload, 32'hDEADBEEF);
    chk("t1_single_pulse", ihit, 0);
    idle(1);

    // Contention: write wins, one idle cycle, then fetch.
    ram_lat = 1; ram_word = 32'h12345678;
    iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    dhc = -1; hitc = -1; v = '0;
    for (int c = 0; c < 10 && hitc < 0; c++) begin
      @(negedge CLK);
      ih = ihit; dh = dhit;
      if (dh) begin
        dhc = c;
        chk("t2_wen", ram_WEN, 1); chk("t2_ren", ram_REN, 0);
        chk("t2_store", ram_store, 32'h55); chk("t2_addr", ram_addr, 32'h200);
      end
      if (ih) begin hitc = c; v = iload; end
      @(posedge CLK); #1;
      if (dh) dWEN = 1'b0;
      if (ih) iREN = 1'b0;
    end
    chk("t2_dhit_cycle", dhc, 1);
    chk("t2_ihit_cycle", hitc, 3);
    chk("t2_iload", v, 32'h12345678);
    idle(2);

    // Starvation: continuous data reads, fetch must win the 5th grant.
    iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h500;
    ndh = 0; hitc = -1;
    for (int c = 0; c < 40 && hitc < 0; c++) begin
      @(negedge CLK);
      if (dhit) ndh++;
      if (ihit) begin hitc = c; a = ram_addr; end
      @(posedge CLK); #1;
    end
    chk("t3_dhits_before_fetch", ndh, SM);
    chk("t3_fetch_addr", a, 32'h400);
    iREN = 1'b0; dREN = 1'b0;
    idle(3);

    // Flush of an in-flight fetch, latency 3, then a new fetch is granted.
    ram_lat = 3; ram_word = 32'hA5A5A5A5;
    iREN = 1'b1; iaddr = 32'h600;
    cnt = 0; hitc = -1; a = '0; v = '0;
    for (int c = 0; c < 14 && hitc < 0; c++) begin
      @(negedge CLK);
      if (c >= 1 && c <= 3 && ram_REN && ram_addr == 32'h600) cnt++;
      if (c == 4) chk("t4_idle_gap", ram_REN, 0);
      if (ihit) begin hitc = c; a = ram_addr; v = iload; end
      @(posedge CLK); #1;
      iflush = (c + 1 == 1);
      if (c + 1 == 1) iaddr = 32'h700;
      if (hitc >= 0) iREN = 1'b0;
    end
    chk("t4_flushed_ren_cycles", cnt, 3);
    chk("t4_refetch_hit_cycle", hitc, 7);
    chk("t4_refetch_addr", a, 32'h700);
    chk("t4_iload", v, 32'hA5A5A5A5);
    idle(2);

    // Reset in the middle of a data read.
    ram_lat = 3; ram_word = 32'h0BADF00D;
    dREN = 1'b1; daddr = 32'h800;
    idle(1);
    @(negedge CLK);
    chk("t5_in_daccess", ram_REN, 1);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("t5_rst_ren", ram_REN, 0); chk("t5_rst_dhit", dhit, 0);
    chk("t5_rst_dload", dload, 0); chk("t5_rst_iload", iload, 0);
    chk("t5_rst_addr", ram_addr, 0);
    dREN = 1'b0;
    idle(2);
    RST = 1'b0;
    ram_lat = 1; ram_word = 32'hCAFEF00D;
    dREN = 1'b1; daddr = 32'h900;
    dhc = -1; v = '0;
    for (int c = 0; c < 8 && dhc < 0; c++) begin
      @(negedge CLK);
      if (dhit) begin dhc = c; v = dload; end
      @(posedge CLK); #1;
      if (dhc >= 0) dREN = 1'b0;
    end
    chk("t5_after_rst_dhit_cycle", dhc, 1);
    chk("t5_after_rst_dload", v, 32'hCAFEF00D);
    idle(2);

    // Random traffic against the model.
    ram_lat = 0; ram_noise = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      ih = ihit; dh = dhit;
      @(posedge CLK); #1;
      if (!iREN || ih) begin
        iREN  = ($urandom % 3 != 0);
        iaddr = $urandom;
      end
      iflush = ($urandom % 10 == 0);
      if (iflush) iaddr = $urandom;
      if (!(dREN || dWEN) || dh) begin
        case ($urandom % 4)
          0: begin dREN = 1'b0; dWEN = 1'b0; end
          1: begin dREN = 1'b1; dWEN = 1'b0; end
          2: begin dREN = 1'b0; dWEN = 1'b1; end
          default: begin dREN = 1'b1; dWEN = 1'b1; end
        endcase
        daddr  = $urandom;
        dstore = $urandom;
      end
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; iflush = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
